// File: rtl/regfile_wr_ctrl_pkg.sv
// Shared types and constants for the register-file write-port controller.
package regfile_wr_ctrl_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned REG_ZERO   = 0;
  localparam int unsigned MAX_WAIT_W = 4;

endpackage

// File: rtl/regfile_wr_ctrl_if.sv
// Writeback, debug and register-file write-port signals of the controller.
interface regfile_wr_ctrl_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
);

  logic          cpu_we;
  logic [AW-1:0] cpu_waddr;
  logic [DW-1:0] cpu_wdata;
  logic          dbg_valid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic          dbg_ready;
  logic          cpu_stall;
  logic          init_done;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  // Requesters and register file side.
  modport master (
    output cpu_we, cpu_waddr, cpu_wdata, dbg_valid, dbg_addr, dbg_data,
    input  dbg_ready, cpu_stall, init_done, rf_we, rf_waddr, rf_wdata
  );

  // Controller side.
  modport slave (
    input  cpu_we, cpu_waddr, cpu_wdata, dbg_valid, dbg_addr, dbg_data,
    output dbg_ready, cpu_stall, init_done, rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/regfile_wr_ctrl_wait_counter.sv
// Saturating count of cycles a debug request has been left waiting.
module wait_counter
  import regfile_wr_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  logic [MAX_WAIT_W-1:0] cnt_q;

  assign at_max_o = (cnt_q == MAX_WAIT_W'(MAX_WAIT));

  // Clear has priority over increment; hold once the limit is reached.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && !at_max_o) begin
      cnt_q <= cnt_q + MAX_WAIT_W'(1);
    end
  end

endmodule

// File: rtl/regfile_wr_ctrl.sv
// Register-file write-port controller: clears r1..r31 after reset, then
// arbitrates the port between CPU writeback (priority) and a debug requester
// with a bounded-wait forced grant.
module regfile_wr_ctrl
  import regfile_wr_ctrl_pkg::*;
#(
  parameter int unsigned NREGS    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  regfile_wr_ctrl_if.slave bus
);

  state_t        state_q;
  logic [AW-1:0] init_cnt_q;

  logic          run_ok;
  logic          cpu_valid;
  logic          dbg_nz;
  logic          at_max;
  logic          wait_inc;
  logic          wait_clr;

  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          dbg_ready;
  logic          cpu_stall;

  // Grants are suppressed in a RUN cycle with reset asserted so a pending
  // debug request is not consumed by a controller that is about to restart.
  assign run_ok    = (state_q == ST_RUN) && rst_n;
  assign cpu_valid = bus.cpu_we && (bus.cpu_waddr != AW'(REG_ZERO));
  assign dbg_nz    = (bus.dbg_addr != AW'(REG_ZERO));

  // FSM and clear-sequence address counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= AW'(1);
    end else if (state_q == ST_INIT) begin
      if (init_cnt_q == AW'(NREGS - 1)) begin
        state_q <= ST_RUN;
      end else begin
        init_cnt_q <= init_cnt_q + AW'(1);
      end
    end
  end

  // Write-port grant mux: init clear, forced debug, CPU, then debug.
  always_comb begin
    rf_we     = 1'b0;
    rf_waddr  = bus.cpu_waddr;
    rf_wdata  = bus.cpu_wdata;
    dbg_ready = 1'b0;
    cpu_stall = 1'b1;
    if (state_q == ST_INIT) begin
      rf_we    = 1'b1;
      rf_waddr = init_cnt_q;
      rf_wdata = '0;
    end else if (run_ok) begin
      if (at_max) begin
        dbg_ready = 1'b1;
        rf_we     = bus.dbg_valid && dbg_nz;
        rf_waddr  = bus.dbg_addr;
        rf_wdata  = bus.dbg_data;
      end else if (cpu_valid) begin
        cpu_stall = 1'b0;
        rf_we     = 1'b1;
      end else begin
        cpu_stall = 1'b0;
        dbg_ready = bus.dbg_valid;
        if (bus.dbg_valid) begin
          rf_we    = dbg_nz;
          rf_waddr = bus.dbg_addr;
          rf_wdata = bus.dbg_data;
        end
      end
    end
  end

  assign wait_inc = bus.dbg_valid && !dbg_ready;
  assign wait_clr = !bus.dbg_valid || dbg_ready;

  wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc_i    (wait_inc),
    .clr_i    (wait_clr),
    .at_max_o (at_max)
  );

  assign bus.rf_we     = rf_we;
  assign bus.rf_waddr  = rf_waddr;
  assign bus.rf_wdata  = rf_wdata;
  assign bus.dbg_ready = dbg_ready;
  assign bus.cpu_stall = cpu_stall;
  assign bus.init_done = (state_q == ST_RUN);

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Scoreboard bench for regfile_wr_ctrl: the driver queues hand-computed
// per-cycle expectations, the monitor checks them on the falling edge.
module tb_regfile_wr_ctrl;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        rdy;
    logic        stall;
    logic        done;
  } exp_t;

  typedef struct {
    string nm;
    exp_t  e;
  } sb_t;

  logic clk;
  logic rst_n;
  sb_t  sb[$];
  int   total;
  int   bad;

  regfile_wr_ctrl_if #(.AW(5), .DW(32)) bus ();

  regfile_wr_ctrl #(
    .NREGS    (32),
    .AW       (5),
    .DW       (32),
    .MAX_WAIT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t E(input logic we, input logic [4:0] a, input logic [31:0] d,
                             input logic r, input logic s, input logic dn);
    exp_t x;
    x.we = we; x.addr = a; x.data = d; x.rdy = r; x.stall = s; x.done = dn;
    return x;
  endfunction

  task automatic cyc(input string nm, input logic rst,
                     input logic cwe, input logic [4:0] ca, input logic [31:0] cd,
                     input logic dv, input logic [4:0] da, input logic [31:0] dd,
                     input exp_t e);
    sb_t s;
    @(posedge clk);
    #1;
    rst_n         = rst;
    bus.cpu_we    = cwe;
    bus.cpu_waddr = ca;
    bus.cpu_wdata = cd;
    bus.dbg_valid = dv;
    bus.dbg_addr  = da;
    bus.dbg_data  = dd;
    s.nm = nm;
    s.e  = e;
    sb.push_back(s);
  endtask

  // Monitor: compare the outputs of every driven cycle against its entry.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t  s;
      exp_t g;
      s = sb.pop_front();
      g = E(bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.dbg_ready, bus.cpu_stall, bus.init_done);
      total++;
      if (g !== s.e) begin
        bad++;
        $display("FAIL %s: got we=%0b addr=%0d data=%h rdy=%0b stall=%0b done=%0b, want we=%0b addr=%0d data=%h rdy=%0b stall=%0b done=%0b",
                 s.nm, g.we, g.addr, g.data, g.rdy, g.stall, g.done,
                 s.e.we, s.e.addr, s.e.data, s.e.rdy, s.e.stall, s.e.done);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.cpu_we = 1'b0; bus.cpu_waddr = '0; bus.cpu_wdata = '0;
    bus.dbg_valid = 1'b0; bus.dbg_addr = '0; bus.dbg_data = '0;

    // Reset state.
    cyc("reset0", 0, 0, 0, 0, 0, 0, 0, E(1, 1, 0, 0, 1, 0));
    cyc("reset1", 0, 0, 0, 0, 0, 0, 0, E(1, 1, 0, 0, 1, 0));

    // Clear sequence: cycle k writes 0 to register k+1.
    for (int k = 0; k < 31; k++)
      cyc("init", 1, 0, 0, 0, 0, 0, 0, E(1, 5'(k + 1), 0, 0, 1, 0));
    cyc("run_idle", 1, 0, 0, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 1));

    // CPU write alone.
    cyc("cpu_wr", 1, 1, 5, 32'hDEADBEEF, 0, 0, 0, E(1, 5, 32'hDEADBEEF, 0, 0, 1));
    // Debug write alone.
    cyc("dbg_wr", 1, 0, 0, 0, 1, 6, 32'h12345678, E(1, 6, 32'h12345678, 1, 0, 1));

    // Continuous CPU writes against a held debug request: 4 waits then force.
    for (int i = 0; i < 4; i++)
      cyc("starve_wait", 1, 1, 5'(10 + i), 32'h100 + 32'(i), 1, 9, 32'hA5A5A5A5,
          E(1, 5'(10 + i), 32'h100 + 32'(i), 0, 0, 1));
    cyc("starve_force", 1, 1, 14, 32'h104, 1, 9, 32'hA5A5A5A5, E(1, 9, 32'hA5A5A5A5, 1, 1, 1));
    cyc("cpu_replay", 1, 1, 14, 32'h104, 0, 0, 0, E(1, 14, 32'h104, 0, 0, 1));
    // Counter back at zero: a fresh debug request waits behind the CPU again.
    cyc("wait_cleared", 1, 1, 15, 32'h105, 1, 8, 32'h88, E(1, 15, 32'h105, 0, 0, 1));
    cyc("dbg_after_cpu", 1, 0, 0, 0, 1, 8, 32'h88, E(1, 8, 32'h88, 1, 0, 1));

    // Address-0 handling.
    cyc("cpu_a0_dbg", 1, 1, 0, 32'hBAD, 1, 7, 32'h77, E(1, 7, 32'h77, 1, 0, 1));
    cyc("dbg_a0", 1, 0, 0, 0, 1, 0, 32'hCAFE, E(0, 0, 32'hCAFE, 1, 0, 1));
    cyc("cpu_a0", 1, 1, 0, 32'h55, 0, 0, 0, E(0, 0, 32'h55, 0, 0, 1));

    // Reset during a pending debug wait.
    cyc("pend_wait0", 1, 1, 3, 32'h33, 1, 12, 32'hC0DE, E(1, 3, 32'h33, 0, 0, 1));
    cyc("pend_wait1", 1, 1, 3, 32'h33, 1, 12, 32'hC0DE, E(1, 3, 32'h33, 0, 0, 1));
    cyc("pend_rst", 0, 1, 3, 32'h33, 1, 12, 32'hC0DE, E(0, 3, 32'h33, 0, 1, 1));
    for (int k = 0; k < 31; k++)
      cyc("reinit", 1, 0, 0, 0, 1, 12, 32'hC0DE, E(1, 5'(k + 1), 0, 0, 1, 0));
    cyc("pend_done", 1, 0, 0, 0, 1, 12, 32'hC0DE, E(1, 12, 32'hC0DE, 1, 1, 1));
    cyc("post_idle", 1, 0, 0, 0, 0, 0, 0, E(0, 0, 0, 0, 0, 1));

    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
